// File: rtl/rx_link_pkg.sv
// Shared types for the receive link controller: FSM states, frame error causes
// and the byte width used by the bit assembler and frame parser.
package rx_link_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_RESYNC,
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_CSUM    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_OVF     = 2'd3
  } rx_err_t;

  function automatic logic is_frame_state(input rx_state_t s);
    return (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/rx_link_controller_assembler.sv
// MSB-first bit assembler shared by sync hunting (full-window compare) and
// byte assembly; its strobes are combinational so the parser reacts in the same cycle.
module rx_byte_assembler
  import rx_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [BYTE_W-1:0] word_next,
  output logic              byte_done,
  output logic              word_full
);

  logic [BYTE_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              filled;

  assign word_next = {shreg[BYTE_W-2:0], bit_in};
  assign byte_done = bit_valid && (bit_cnt == 3'd7);
  // A window compare is only meaningful once eight real bits sit in the register.
  assign word_full = bit_valid && (filled || (bit_cnt == 3'd7));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      filled  <= 1'b0;
    end else if (clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
      filled  <= 1'b0;
    end else if (bit_valid) begin
      shreg   <= word_next;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) filled <= 1'b1;
    end
  end

endmodule

// File: rtl/rx_link_controller.sv
// Frame controller for the oversampling receiver: resync, sync hunt,
// length/payload/checksum parsing and valid/ready byte delivery.
module rx_link_controller
  import rx_link_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD     = 8'hA7,
  parameter int         MAX_LEN       = 64,
  parameter int         RESYNC_CYCLES = 16,
  parameter int         BIT_TIMEOUT   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       rx_rst,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int RS_W  = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
  localparam int TMO_W = (BIT_TIMEOUT > 1) ? $clog2(BIT_TIMEOUT) : 1;
  localparam logic [RS_W-1:0]   RS_LAST   = RS_W'(RESYNC_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(BIT_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] MAX_LEN_B = BYTE_W'(MAX_LEN);

  rx_state_t         state;
  logic [RS_W-1:0]   rs_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BYTE_W-1:0] len_r;
  logic [BYTE_W-1:0] pay_cnt;
  logic [BYTE_W-1:0] acc;

  logic [BYTE_W-1:0] word_next;
  logic              byte_done;
  logic              word_full;
  logic              in_frame;
  logic              sync_hit;
  logic              tmo_hit;
  logic              pay_last;
  logic              len_bad;
  logic              ovf;
  logic              clear;

  assign in_frame = is_frame_state(state);
  assign sync_hit = (state == ST_HUNT) && word_full && (word_next == SYNC_WORD);
  assign tmo_hit  = in_frame && !bit_valid && (tmo_cnt == TMO_LAST);
  assign pay_last = (pay_cnt == (len_r - 8'd1));
  assign len_bad  = (word_next == '0) || (word_next > MAX_LEN_B);
  assign ovf      = byte_valid && !byte_ready;
  // Restart bit alignment whenever the parser changes phase; RESYNC keeps it flushed.
  assign clear    = (state == ST_RESYNC) || sync_hit || tmo_hit || (byte_done && in_frame);

  rx_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word_next (word_next),
    .byte_done (byte_done),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RESYNC;
      rx_rst     <= 1'b1;
      rs_cnt     <= '0;
      tmo_cnt    <= '0;
      len_r      <= '0;
      pay_cnt    <= '0;
      acc        <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_last <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= ERR_CSUM;
      busy       <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (byte_valid && byte_ready) byte_valid <= 1'b0;

      if (!in_frame || bit_valid || tmo_hit) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + 1'b1;

      case (state)
        ST_RESYNC: begin
          if (rs_cnt == RS_LAST) begin
            rs_cnt <= '0;
            rx_rst <= 1'b0;
            state  <= ST_HUNT;
          end else begin
            rs_cnt <= rs_cnt + 1'b1;
          end
        end
        ST_HUNT: begin
          if (sync_hit) begin
            state <= ST_LEN;
            busy  <= 1'b1;
          end
        end
        ST_LEN: begin
          if (byte_done) begin
            if (len_bad) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              rx_rst    <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_RESYNC;
            end else begin
              len_r   <= word_next;
              acc     <= word_next;
              pay_cnt <= '0;
              state   <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (byte_done) begin
            // An unaccepted byte would be overwritten; abort instead of dropping data.
            if (ovf) begin
              frame_err  <= 1'b1;
              err_code   <= ERR_OVF;
              byte_valid <= 1'b0;
              rx_rst     <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_RESYNC;
            end else begin
              byte_out   <= word_next;
              byte_valid <= 1'b1;
              frame_last <= pay_last;
              acc        <= acc ^ word_next;
              pay_cnt    <= pay_cnt + 8'd1;
              if (pay_last) state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (byte_done) begin
            if (word_next == acc) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            busy  <= 1'b0;
            state <= ST_HUNT;
          end
        end
        default: begin
          rx_rst <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_RESYNC;
        end
      endcase

      // Timeout only fires on a clock without bit_valid, so it never collides with a byte event.
      if (tmo_hit) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        rx_rst    <= 1'b1;
        busy      <= 1'b0;
        state     <= ST_RESYNC;
      end
    end
  end

endmodule

// File: tb/tb_rx_link_controller.sv
// Scoreboard bench for rx_link_controller: expected bytes and frame events are
// queued as frames are driven and compared when the DUT produces them.
module tb_rx_link_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       byte_ready = 1'b1;
  logic       rx_rst;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       frame_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  exp_byte_t  byte_q[$];
  logic [3:0] evt_q[$];
  exp_byte_t  mon_b;
  logic [3:0] mon_e;
  logic [3:0] obs_e;

  localparam logic [3:0] EVT_OK = 4'b1000;

  always #5 clk = ~clk;

  rx_link_controller dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .rx_rst     (rx_rst),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .frame_last (frame_last),
    .frame_ok   (frame_ok),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  // Scoreboard monitor: byte transfers and frame events, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (byte_valid && byte_ready) begin
        checks++;
        if (byte_q.size() == 0) begin
          failures++;
          $display("FAIL byte_xfer: got byte %h last=%b, no byte expected", byte_out, frame_last);
        end else begin
          mon_b = byte_q.pop_front();
          if ({byte_out, frame_last} !== {mon_b.data, mon_b.last}) begin
            failures++;
            $display("FAIL byte_xfer: got %h last=%b, required %h last=%b",
                     byte_out, frame_last, mon_b.data, mon_b.last);
          end
        end
      end
      if (frame_ok || frame_err) begin
        checks++;
        obs_e = {frame_ok, frame_err, (frame_err ? err_code : 2'b00)};
        if (evt_q.size() == 0) begin
          failures++;
          $display("FAIL frame_event: got ok=%b err=%b code=%0d, no event expected",
                   frame_ok, frame_err, err_code);
        end else begin
          mon_e = evt_q.pop_front();
          if (obs_e !== mon_e) begin
            failures++;
            $display("FAIL frame_event: got {ok,err,code}=%b, required %b", obs_e, mon_e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1);
  endtask

  task automatic wait_hunt(input string tag);
    int n = 0;
    while (rx_rst === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (rx_rst !== 1'b0) begin
      failures++;
      $display("FAIL %s_resync_done: rx_rst=%b after %0d clocks, required 0", tag, rx_rst, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rx_rst, byte_out, byte_valid, frame_last, frame_ok, frame_err, err_code, busy} !==
        {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      failures++;
      $display("FAIL reset_values: rx_rst=%b byte_out=%h vld=%b last=%b ok=%b err=%b code=%0d busy=%b, required rx_rst=1 others 0",
               rx_rst, byte_out, byte_valid, frame_last, frame_ok, frame_err, err_code, busy);
    end
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (rx_rst !== (i < 16)) begin
        failures++;
        $display("FAIL reset_resync_len: edge %0d rx_rst=%b, required %b", i, rx_rst, (i < 16));
      end
    end
  endtask

  task automatic test_good_frame();
    byte_ready = 1'b1;
    byte_q.push_back('{data: 8'h3C, last: 1'b0});
    byte_q.push_back('{data: 8'h81, last: 1'b1});
    evt_q.push_back(EVT_OK);
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h3C);
    checks++;
    if ({byte_valid, byte_out, busy} !== {1'b1, 8'h3C, 1'b1}) begin
      failures++;
      $display("FAIL good_byte_latency: vld=%b byte=%h busy=%b, required vld=1 byte=3c busy=1",
               byte_valid, byte_out, busy);
    end
    send_byte(8'h81);
    send_byte(8'hBF);
    checks++;
    if ({frame_ok, frame_err, busy} !== 3'b100) begin
      failures++;
      $display("FAIL good_ok_pulse: ok=%b err=%b busy=%b, required ok=1 err=0 busy=0",
               frame_ok, frame_err, busy);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (rx_rst !== 1'b0 || byte_q.size() != 0 || evt_q.size() != 0) begin
      failures++;
      $display("FAIL good_drain: rx_rst=%b bytes_left=%0d events_left=%0d, required 0/0/0",
               rx_rst, byte_q.size(), evt_q.size());
    end
  endtask

  task automatic test_bad_csum();
    byte_q.push_back('{data: 8'h3C, last: 1'b0});
    byte_q.push_back('{data: 8'h81, last: 1'b1});
    evt_q.push_back({2'b01, 2'd0});
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h3C);
    send_byte(8'h81);
    send_byte(8'h00);
    checks++;
    if ({frame_err, err_code, busy} !== {1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL csum_err: err=%b code=%0d busy=%b, required err=1 code=0 busy=0",
               frame_err, err_code, busy);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (rx_rst !== 1'b0 || byte_q.size() != 0 || evt_q.size() != 0) begin
      failures++;
      $display("FAIL csum_no_resync: rx_rst=%b bytes_left=%0d events_left=%0d, required 0/0/0",
               rx_rst, byte_q.size(), evt_q.size());
    end
  endtask

  task automatic test_back_to_back();
    byte_q.push_back('{data: 8'h55, last: 1'b1});
    evt_q.push_back(EVT_OK);
    send_byte(8'hA7);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h54);
    checks++;
    if (frame_ok !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ok: ok=%b, required 1", frame_ok);
    end
  endtask

  task automatic test_len_err(input logic [7:0] len);
    int n = 0;
    evt_q.push_back({2'b01, 2'd1});
    send_byte(8'hA7);
    send_byte(len);
    checks++;
    if ({frame_err, err_code, rx_rst} !== {1'b1, 2'd1, 1'b1}) begin
      failures++;
      $display("FAIL len_err_%0d: err=%b code=%0d rx_rst=%b, required err=1 code=1 rx_rst=1",
               len, frame_err, err_code, rx_rst);
    end
    while (rx_rst === 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL len_resync_len_%0d: rx_rst high %0d clocks, required 16", len, n);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    evt_q.push_back({2'b01, 2'd2});
    send_byte(8'hA7);
    send_byte(8'h01);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    while (frame_err !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 200 || err_code !== 2'd2 || rx_rst !== 1'b1) begin
      failures++;
      $display("FAIL timeout: err after %0d idle clocks code=%0d rx_rst=%b, required 200 code=2 rx_rst=1",
               n, err_code, rx_rst);
    end
    wait_hunt("timeout");
  endtask

  task automatic test_overflow();
    byte_ready = 1'b0;
    evt_q.push_back({2'b01, 2'd3});
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({byte_valid, byte_out, frame_last} !== {1'b1, 8'h11, 1'b0}) begin
      failures++;
      $display("FAIL ovf_hold: vld=%b byte=%h last=%b, required vld=1 byte=11 last=0",
               byte_valid, byte_out, frame_last);
    end
    send_byte(8'h22);
    checks++;
    if ({frame_err, err_code, byte_valid, rx_rst} !== {1'b1, 2'd3, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL ovf_err: err=%b code=%0d vld=%b rx_rst=%b, required err=1 code=3 vld=0 rx_rst=1",
               frame_err, err_code, byte_valid, rx_rst);
    end
    byte_ready = 1'b1;
    wait_hunt("overflow");
  endtask

  task automatic test_ready_at_collision();
    logic [7:0] b2;
    b2 = 8'h22;
    byte_ready = 1'b0;
    byte_q.push_back('{data: 8'h11, last: 1'b0});
    byte_q.push_back('{data: 8'h22, last: 1'b1});
    evt_q.push_back(EVT_OK);
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h11);
    for (int i = 7; i >= 1; i--) send_bit(b2[i], 1);
    @(posedge clk);
    #1;
    byte_ready = 1'b1;
    bit_in     = b2[0];
    bit_valid  = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    checks++;
    if ({byte_valid, byte_out, frame_last, frame_err} !== {1'b1, 8'h22, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL collision_load: vld=%b byte=%h last=%b err=%b, required vld=1 byte=22 last=1 err=0",
               byte_valid, byte_out, frame_last, frame_err);
    end
    send_byte(8'h31);
    checks++;
    if (frame_ok !== 1'b1) begin
      failures++;
      $display("FAIL collision_ok: ok=%b, required 1", frame_ok);
    end
  endtask

  task automatic test_false_sync();
    evt_q.push_back({2'b01, 2'd1});
    send_byte(8'hA7);
    send_byte(8'h00);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    checks++;
    if (rx_rst !== 1'b1) begin
      failures++;
      $display("FAIL false_sync_in_resync: rx_rst=%b, required 1", rx_rst);
    end
    wait_hunt("false_sync");
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy !== 1'b0 || evt_q.size() != 0) begin
      failures++;
      $display("FAIL false_sync: busy=%b events_left=%0d, required busy=0 events_left=0",
               busy, evt_q.size());
    end
    byte_q.push_back('{data: 8'h55, last: 1'b1});
    evt_q.push_back(EVT_OK);
    send_byte(8'hA7);
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h54);
    checks++;
    if (frame_ok !== 1'b1) begin
      failures++;
      $display("FAIL false_sync_recover: ok=%b, required 1", frame_ok);
    end
  endtask

  task automatic test_reset_midframe();
    byte_ready = 1'b0;
    send_byte(8'hA7);
    send_byte(8'h02);
    send_byte(8'h3C);
    rst = 1'b0;
    #2;
    checks++;
    if ({byte_valid, frame_err, rx_rst, busy} !== 4'b0010) begin
      failures++;
      $display("FAIL midframe_reset: vld=%b err=%b rx_rst=%b busy=%b, required vld=0 err=0 rx_rst=1 busy=0",
               byte_valid, frame_err, rx_rst, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    byte_ready = 1'b1;
    wait_hunt("midframe");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_back_to_back();
    test_len_err(8'h00);
    test_len_err(8'd65);
    test_timeout();
    test_overflow();
    test_ready_at_collision();
    test_false_sync();
    test_reset_midframe();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (byte_q.size() != 0 || evt_q.size() != 0) begin
      failures++;
      $display("FAIL final_drain: bytes_left=%0d events_left=%0d, required 0/0",
               byte_q.size(), evt_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_link_controller.md
# rx_link_controller

Frame-level controller for the oversampling `hardware_receiver`. It holds the receiver in reset for a fixed resync period, then hunts the recovered bit stream (`dout`/`vout`) for a sync word. It parses a length-prefixed frame with an XOR checksum and delivers payload bytes downstream over a valid/ready handshake. It also resets the receiver again after unrecoverable link errors.

## Interface
Parameters:
- `SYNC_WORD`, 8'hA7: frame sync pattern, compared MSB-first.
- `MAX_LEN`, 64: maximum legal payload length in bytes.
- `RESYNC_CYCLES`, 16: number of clocks `rx_rst` is held high after reset or a link error.
- `BIT_TIMEOUT`, 200: maximum clocks allowed between `bit_valid` pulses inside a frame.

Ports:
- `clk`  in  1  system clock, the same clock as `hardware_receiver`.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low (asserted at 0).
- `bit_in`  in  1  recovered bit (receiver `dout`).
- `bit_valid`  in  1  single-cycle strobe that qualifies `bit_in` (receiver `vout`).
- `rx_rst`  out  1  active-high reset to `hardware_receiver`.
- `byte_out`  out  8  payload byte.
- `byte_valid`  out  1  `byte_out` is valid; held until accepted.
- `byte_ready`  in  1  downstream accept.
- `frame_last`  out  1  qualifies the final payload byte of the frame, valid with `byte_valid`.
- `frame_ok`  out  1  one-cycle pulse: checksum matched.
- `frame_err`  out  1  one-cycle pulse: frame aborted.
- `err_code`  out  2  cause of the last `frame_err`: 0 checksum, 1 length, 2 timeout, 3 overflow. Holds until the next `frame_err`.
- `busy`  out  1  high in LEN, PAYLOAD and CSUM.

## Operation
- States: RESYNC, HUNT, LEN, PAYLOAD, CSUM.
- RESYNC
  - `rx_rst`=1 and the counter increments.
  - After RESYNC_CYCLES clocks, go to HUNT.
  - `bit_valid` is ignored.
- HUNT
  - The 8-bit shift register clears on entry and shifts on each `bit_valid`.
  - When the register equals SYNC_WORD after a shift: clear the bit counter and go to LEN.
  - A match requires at least 8 bits received since entry.
- Byte assembly: shift MSB-first; 3-bit counter; a byte is complete on the 8th `bit_valid`.
- LEN
  - Byte L completes. If L==0 or L>MAX_LEN: `frame_err`, code 1, go to RESYNC.
  - Otherwise: store L, checksum accumulator = L, go to PAYLOAD.
- PAYLOAD
  - Each complete byte is XORed into the accumulator, loaded into `byte_out`, and `byte_valid` is set.
  - `frame_last` is set on byte L.
  - After byte L, go to CSUM.
- CSUM
  - Byte equals the accumulator: `frame_ok`.
  - Otherwise: `frame_err`, code 0.
  - Either way, go to HUNT. A checksum error does not resync the receiver.
- Timeout
  - The counter clears on every `bit_valid` and on state entry, and runs only in LEN, PAYLOAD and CSUM.
  - Reaching BIT_TIMEOUT: `frame_err`, code 2, go to RESYNC.
- Handshake
  - A byte transfers when `byte_valid` and `byte_ready` are both high; `byte_valid` drops the next cycle unless a new byte loads.
  - `byte_out` and `frame_last` are stable while `byte_valid`=1 and `byte_ready`=0.
- Overflow
  - Occurs when a new payload byte completes while `byte_valid`=1 and `byte_ready`=0 in that same cycle.
  - Response: `frame_err`, code 3, `byte_valid` cleared, go to RESYNC.
  - If `byte_ready`=1 in that cycle, the old byte transfers and the new one loads; this is not an overflow.
- Simultaneous events: an overflow or length error in the same cycle as a timeout reports the non-timeout code.

## Timing
- Reset values:
  - state = RESYNC, `rx_rst` = 1.
  - `byte_out` = 0, `byte_valid` = 0, `frame_last` = 0.
  - `frame_ok` = 0, `frame_err` = 0, `err_code` = 0, `busy` = 0.
  - All counters and the accumulator = 0.
- Reset assertion mid-frame aborts immediately and silently: no `frame_err`, and a pending byte is discarded.
- On release, `rx_rst` stays high for exactly RESYNC_CYCLES rising edges.
- Latency from a byte-completing `bit_valid` in cycle t:
  - `byte_valid`, `frame_ok` and `frame_err` assert in cycle t+1.
  - The state change is visible in cycle t+1.
- Timeout fires on the BIT_TIMEOUT-th consecutive clock without `bit_valid`. `frame_err` asserts in the following cycle.
- All outputs are registered.

## Structure
- Package `rx_link_pkg`: state enum `rx_state_t`, error enum `rx_err_t` (ERR_CSUM, ERR_LEN, ERR_TIMEOUT, ERR_OVF), and byte width constant 8.
- Sub-module `rx_byte_assembler` contains the shift register, bit counter, `clear` input and `byte_done` strobe. It is reused for HUNT comparison (full-register output) and byte assembly.

## Test plan
- Reset: drive `rst`=0, then release → `rx_rst`=1 for 16 clocks then 0; all other outputs at reset values.
- Good frame: A7, 02, 3C, 81, BF → bytes 3C then 81, `frame_last` on 81, `frame_ok` pulse, `rx_rst` stays 0.
- Bad checksum: A7, 02, 3C, 81, 00 → both bytes delivered, `frame_err` with `err_code`=0, HUNT, no resync.
- Length error: A7, 00 → `frame_err` with `err_code`=1, `rx_rst` high for 16 clocks. Repeat with L=65.
- Timeout: A7, 01, then 3 payload bits followed by 200 idle clocks → `frame_err` with `err_code`=2, resync.
- Overflow and false sync: `byte_ready`=0 across two payload bytes → `err_code`=3. Noise 10100111 split across a resync boundary → no frame detected.
